// File: rtl/tff_counter.sv
// ---------------------------------------------------------------------------
// tff_counter
//   Bank of WIDTH toggle stages on one clock, generalised into a modulo-N
//   up/down counter with free-run, one-shot, per-bit toggle and hold modes.
//
// Parameters
//   WIDTH    number of stages / bits of q
//   MODULUS  count range 0..MODULUS-1 in the count modes (2..2**WIDTH)
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-low reset
//   en    in   count / toggle enable
//   up    in   count direction: 1 up, 0 down
//   load  in   synchronous load of d (priority over en)
//   d     in   load value, or toggle mask in mode 10
//   mode  in   00 free-run wrap, 01 one-shot, 10 toggle-register, 11 hold
//   q     out  current state (registered)
//   qbar  out  bitwise inverse of q
//   tc    out  terminal count (combinational from q, up, mode)
//   done  out  sticky one-shot completion flag (registered)
// ---------------------------------------------------------------------------
module tff_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  // One bit wider so the range test stays meaningful when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             count_mode_s;
  logic             at_max_s;
  logic             at_zero_s;
  logic             out_of_range_s;
  logic             d_out_of_range_s;
  logic [WIDTH-1:0] step_s;
  logic             tc_s;

  // Decode of the current state and the next count step.
  always_comb begin
    count_mode_s     = (mode[1] == 1'b0);
    at_max_s         = (cnt_q == MAX_VAL);
    at_zero_s        = (cnt_q == ZERO_VAL);
    out_of_range_s   = ({1'b0, cnt_q} >= MOD_EXT);
    d_out_of_range_s = ({1'b0, d} >= MOD_EXT);
    // An out-of-range value (left over from modes 10/11) re-enters the
    // range at the wrap point of whichever direction is stepping.
    if (up) begin
      if (at_max_s || out_of_range_s) begin
        step_s = ZERO_VAL;
      end else begin
        step_s = cnt_q + ONE_VAL;
      end
    end else begin
      if (at_zero_s || out_of_range_s) begin
        step_s = MAX_VAL;
      end else begin
        step_s = cnt_q - ONE_VAL;
      end
    end
    tc_s = count_mode_s && ((up && at_max_s) || (!up && at_zero_s));
  end

  // Next-state selection: load beats enable, enable beats hold.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (load) begin
      if (count_mode_s && d_out_of_range_s) begin
        cnt_d = MAX_VAL;
      end else begin
        cnt_d = d;
      end
      done_d = 1'b0;
    end else if (en) begin
      case (mode)
        2'b00: cnt_d = step_s;
        2'b01: begin
          // Once finished the counter parks until a load; the edge that
          // sees terminal count only raises done and does not move q.
          if (done_q) begin
            cnt_d = cnt_q;
          end else if (tc_s) begin
            done_d = 1'b1;
          end else begin
            cnt_d = step_s;
          end
        end
        2'b10:   cnt_d = cnt_q ^ d;
        2'b11:   cnt_d = cnt_q;
        default: cnt_d = cnt_q;
      endcase
    end else begin
      cnt_d  = cnt_q;
      done_d = done_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= ZERO_VAL;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q    = cnt_q;
  assign qbar = ~cnt_q;
  assign tc   = tc_s;
  assign done = done_q;

endmodule

// File: tb/tb_tff_counter.sv
module tb_tff_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] d;
  logic [1:0] mode;
  logic [3:0] q;
  logic [3:0] qbar;
  logic       tc;
  logic       done;

  int n_checks;
  int n_fail;

  tff_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .d    (d),
    .mode (mode),
    .q    (q),
    .qbar (qbar),
    .tc   (tc),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] m, input logic [3:0] v);
    mode = m; d = v; load = 1'b1; en = 1'b0;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; d = 4'd0; mode = 2'b00;
    #2;
    n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL reset_q: got %0d want 0", q); end
    n_checks++; if (qbar !== 4'hF) begin n_fail++; $display("FAIL reset_qbar: got %h want f", qbar); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (tc !== 1'b1) begin n_fail++; $display("FAIL reset_tc: got %b want 1", tc); end
    step();
    rst = 1'b1;
    step();
    // Drive to q=9 with done set via one-shot, then reset mid-cycle.
    do_load(2'b01, 4'd8);
    up = 1'b1; en = 1'b1;
    step();
    step();
    n_checks++; if (q !== 4'd9 || done !== 1'b1) begin n_fail++; $display("FAIL pre_reset: got q=%0d done=%b want q=9 done=1", q, done); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (q !== 4'd0 || qbar !== 4'hF || done !== 1'b0) begin n_fail++; $display("FAIL async_reset: got q=%0d qbar=%h done=%b want 0 f 0", q, qbar, done); end
    step();
    step();
    n_checks++; if (q !== 4'd0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got q=%0d done=%b want 0 0", q, done); end
    rst = 1'b1;
    en = 1'b0;
    step();
  endtask

  task automatic test_free_run();
    logic [3:0] exp;
    do_load(2'b00, 4'd0);
    up = 1'b1; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp = 4'(i % 10);
      n_checks++;
      if (q !== exp || qbar !== ~exp || tc !== (exp == 4'd9)) begin
        n_fail++;
        $display("FAIL free_up[%0d]: got q=%0d qbar=%h tc=%b want q=%0d", i, q, qbar, tc, exp);
      end
    end
    en = 1'b0;
    do_load(2'b00, 4'd0);
    up = 1'b0; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp = 4'((10 - (i % 10)) % 10);
      n_checks++;
      if (q !== exp || tc !== (exp == 4'd0)) begin
        n_fail++;
        $display("FAIL free_down[%0d]: got q=%0d tc=%b want q=%0d", i, q, tc, exp);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_q [4];
    logic       exp_tc [4];
    logic       exp_done [4];
    exp_q    = '{4'd8, 4'd9, 4'd9, 4'd9};
    exp_tc   = '{1'b0, 1'b1, 1'b1, 1'b1};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b1};
    up = 1'b1;
    do_load(2'b01, 4'd7);
    n_checks++; if (q !== 4'd7 || done !== 1'b0) begin n_fail++; $display("FAIL os_load: got q=%0d done=%b want 7 0", q, done); end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (q !== exp_q[i] || tc !== exp_tc[i] || done !== exp_done[i]) begin
        n_fail++;
        $display("FAIL one_shot[%0d]: got q=%0d tc=%b done=%b want q=%0d tc=%b done=%b",
                 i, q, tc, done, exp_q[i], exp_tc[i], exp_done[i]);
      end
    end
    // Mode change alone must not clear done; counting in mode 00 still works.
    mode = 2'b00;
    step();
    n_checks++; if (done !== 1'b1 || q !== 4'd0) begin n_fail++; $display("FAIL os_mode_change: got q=%0d done=%b want 0 1", q, done); end
    do_load(2'b01, 4'd3);
    n_checks++; if (q !== 4'd3 || done !== 1'b0) begin n_fail++; $display("FAIL os_reload: got q=%0d done=%b want 3 0", q, done); end
  endtask

  task automatic test_toggle();
    logic [3:0] exp [3];
    exp = '{4'b0101, 4'b0000, 4'b0101};
    do_load(2'b10, 4'b0000);
    d = 4'b0101; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (q !== exp[i] || tc !== 1'b0) begin
        n_fail++;
        $display("FAIL toggle[%0d]: got q=%b tc=%b want q=%b tc=0", i, q, tc, exp[i]);
      end
    end
    mode = 2'b11;
    step();
    step();
    n_checks++; if (q !== 4'b0101) begin n_fail++; $display("FAIL hold_mode: got q=%b want 0101", q); end
    en = 1'b0;
  endtask

  task automatic test_clamp();
    do_load(2'b00, 4'd13);
    n_checks++; if (q !== 4'd9) begin n_fail++; $display("FAIL clamp_m00: got q=%0d want 9", q); end
    do_load(2'b01, 4'd15);
    n_checks++; if (q !== 4'd9) begin n_fail++; $display("FAIL clamp_m01: got q=%0d want 9", q); end
    do_load(2'b10, 4'd13);
    n_checks++; if (q !== 4'd13 || tc !== 1'b0) begin n_fail++; $display("FAIL noclamp_m10: got q=%0d tc=%b want 13 0", q, tc); end
    mode = 2'b00; up = 1'b1;
    #1;
    n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL oor_tc_up: got tc=%b want 0", tc); end
    en = 1'b1;
    step();
    en = 1'b0;
    n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL oor_up_step: got q=%0d want 0", q); end
    do_load(2'b11, 4'd13);
    n_checks++; if (q !== 4'd13) begin n_fail++; $display("FAIL noclamp_m11: got q=%0d want 13", q); end
    mode = 2'b00; up = 1'b0;
    #1;
    n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL oor_tc_down: got tc=%b want 0", tc); end
    en = 1'b1;
    step();
    en = 1'b0;
    n_checks++; if (q !== 4'd9) begin n_fail++; $display("FAIL oor_down_step: got q=%0d want 9", q); end
  endtask

  task automatic test_priority();
    up = 1'b1;
    do_load(2'b00, 4'd2);
    d = 4'd5; load = 1'b1; en = 1'b1;
    step();
    load = 1'b0; en = 1'b0;
    n_checks++; if (q !== 4'd5) begin n_fail++; $display("FAIL load_over_en: got q=%0d want 5", q); end
    do_load(2'b00, 4'd9);
    up = 1'b1;
    #1;
    n_checks++; if (tc !== 1'b1) begin n_fail++; $display("FAIL tc_comb_up: got tc=%b want 1", tc); end
    up = 1'b0;
    #1;
    n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL tc_comb_down: got tc=%b want 0", tc); end
    step();
    up = 1'b1;
    step();
    n_checks++; if (q !== 4'd9) begin n_fail++; $display("FAIL en_low_hold: got q=%0d want 9", q); end
    do_load(2'b01, 4'd0);
    up = 1'b0;
    #1;
    n_checks++; if (tc !== 1'b1) begin n_fail++; $display("FAIL tc_zero_down: got tc=%b want 1", tc); end
    mode = 2'b10;
    #1;
    n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL tc_mode10: got tc=%b want 0", tc); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_free_run();
    test_one_shot();
    test_toggle();
    test_clamp();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
